// File: rtl/mem_bus_unit.sv
// -----------------------------------------------------------------------------
// mem_bus_unit
//
// Sequenced memory bus unit between the core datapath and external memory.
// One access is accepted at a time from IDLE, then walks SETUP -> ACCESS ->
// DONE. ACCESS waits for mem_ready_i with a bounded wait counter. An access
// that sees no mem_ready_i within TIMEOUT cycles is aborted with err_o.
//
// Handshake: req_i is looked at only while the unit is IDLE. A req_i that
// arrives in any other state is dropped, not queued, so the core must
// re-assert it. Each accepted request (and each reserved-op request) ends
// with exactly one done_o pulse. err_o is only ever high together with
// done_o. mem_ready_i is looked at only while the unit is in ACCESS.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_ni       asynchronous active-low reset
//   req_i        access request (IDLE only)
//   op_i         00 fetch, 01 load, 10 store, 11 reserved
//   addr_i       access address, captured with req_i
//   wdata_i      store data, captured with req_i
//   busy_o       access in flight (SETUP/ACCESS/DONE of a real access)
//   done_o       one-cycle completion pulse
//   err_o        one-cycle error pulse, coincident with done_o
//   rdata_o      data of the last successful load
//   instr_o      instruction register, data of the last successful fetch
//   mem_addr_o   registered memory address
//   mem_wdata_o  registered store data
//   mem_rd_o     read strobe (ACCESS of fetch/load only)
//   mem_wr_o     write strobe (ACCESS of store only)
//   mem_rdata_i  memory read data
//   mem_ready_i  memory completion
//   state_o      current FSM state, for observation
// -----------------------------------------------------------------------------
module mem_bus_unit #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_i,
    input  logic [1:0]    op_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [DW-1:0] rdata_o,
    output logic [DW-1:0] instr_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_rd_o,
    output logic          mem_wr_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ready_i,
    output logic [1:0]    state_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    localparam logic [1:0] OP_FETCH = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        DONE   = 2'b11
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          err_q, err_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] instr_q, instr_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_FETCH;
            err_q   <= 1'b0;
            wait_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            err_q   <= err_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        err_d   = err_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        instr_d = instr_q;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    op_d = op_i;
                    if (op_i == OP_RSV) begin
                        // Reserved op completes straight away with an error;
                        // the memory side is never touched.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        addr_d  = addr_i;
                        wdata_d = wdata_i;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (mem_ready_i) begin
                    // A ready on the last allowed cycle still counts as success.
                    if (op_q == OP_FETCH) begin
                        instr_d = mem_rdata_i;
                    end else if (op_q == OP_LOAD) begin
                        rdata_d = mem_rdata_i;
                    end
                    state_d = DONE;
                end else begin
                    // Leaves ACCESS as soon as the count reaches TIMEOUT,
                    // so the counter can never wrap.
                    wait_d = wait_q + CW'(1);
                    if (wait_d == TIMEOUT_C) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output below comes from registers only; strobes follow state_q
    // so an asynchronous reset drops them without waiting for a clock edge.
    assign busy_o      = (state_q != IDLE) && !((state_q == DONE) && (op_q == OP_RSV));
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == DONE) && err_q;
    assign mem_rd_o    = (state_q == ACCESS) && (op_q != OP_STORE);
    assign mem_wr_o    = (state_q == ACCESS) && (op_q == OP_STORE);
    assign rdata_o     = rdata_q;
    assign instr_o     = instr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_bus_unit.sv
module tb_mem_bus_unit;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int TIMEOUT = 15;
  localparam int W = 49;

  logic clk = 1'b0;
  logic rst_n;
  logic req;
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic busy, done, err;
  logic [DW-1:0] rdata, instr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata;
  logic mem_ready;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // expected {err, instr, rdata, strobe cycles, latency}
  logic [W-1:0] exp_q[$];
  int acc_q[$];

  logic [DW-1:0] tb_mem [256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] ref_instr, ref_rdata;
  int cur_waits;
  int acc_cnt;
  int strobe_cnt;

  mem_bus_unit #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .op_i(op), .addr_i(addr),
    .wdata_i(wdata), .busy_o(busy), .done_o(done), .err_o(err),
    .rdata_o(rdata), .instr_o(instr), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr),
    .mem_rdata_i(mem_rdata), .mem_ready_i(mem_ready), .state_o(state)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Drive one request; the reference model decides the outcome from the
  // op, the number of not-ready cycles the memory will insert, and TIMEOUT.
  task automatic start(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input int waits, input bit expect_done);
    int strobes, lat;
    logic e;
    req = 1'b1; op = o; addr = a; wdata = wd; cur_waits = waits;
    if (o == 2'b11) begin
      e = 1'b1; strobes = 0; lat = 1;
    end else begin
      strobes = (waits < TIMEOUT) ? waits + 1 : TIMEOUT;
      lat = 2 + strobes;
      e = (waits >= TIMEOUT);
      if (!e && expect_done) begin
        case (o)
          2'b00: ref_instr = ref_mem[a[7:0]];
          2'b01: ref_rdata = ref_mem[a[7:0]];
          default: ref_mem[a[7:0]] = wd;
        endcase
      end
    end
    if (expect_done) exp_q.push_back({e, ref_instr, ref_rdata, 8'(strobes), 8'(lat)});
    @(posedge clk);
    #1;
    if (expect_done) acc_q.push_back(cyc);
    req = 1'b0; op = 2'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (state != 2'b00 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (state != 2'b00) check("idle_wait_expired", 64'(state), 64'(0));
  endtask

  task automatic run(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input int waits);
    start(o, a, wd, waits, 1'b1);
    wait_idle();
  endtask

  initial begin
    logic [W-1:0] e;
    int a;
    int r, w;
    rst_n = 1'b0; req = 1'b0; op = 2'b00; addr = '0; wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0; cur_waits = 0; acc_cnt = 0; strobe_cnt = 0;
    ref_instr = '0; ref_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = DW'($urandom);
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 16'hA5C3;
    ref_mem[16] = 16'hA5C3;

    fork
      // memory responder: ready after cur_waits not-ready ACCESS cycles
      forever begin
        @(negedge clk);
        if (mem_rd || mem_wr) begin
          acc_cnt++;
          mem_ready = (acc_cnt > cur_waits);
          mem_rdata = tb_mem[mem_addr[7:0]];
          if (mem_wr && mem_ready) tb_mem[mem_addr[7:0]] = mem_wdata;
        end else begin
          acc_cnt = 0;
          mem_ready = 1'($urandom_range(0, 1));
          mem_rdata = DW'($urandom);
        end
      end
      // monitor / scoreboard
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          strobe_cnt = 0;
        end else begin
          check("strobe_excl", 64'(mem_rd & mem_wr), 64'(0));
          if (mem_rd || mem_wr) strobe_cnt++;
          if (done) begin
            if (exp_q.size() == 0 || acc_q.size() == 0) begin
              check("unexpected_done", 64'(1), 64'(0));
            end else begin
              e = exp_q.pop_front();
              a = acc_q.pop_front();
              check("err", 64'(err), 64'(e[48]));
              check("instr", 64'(instr), 64'(e[47:32]));
              check("rdata", 64'(rdata), 64'(e[31:16]));
              check("strobe_cycles", 64'(strobe_cnt), 64'(e[15:8]));
              check("latency", 64'(cyc - a + 1), 64'(e[7:0]));
            end
            strobe_cnt = 0;
          end else begin
            check("err_without_done", 64'(err), 64'(0));
          end
        end
      end
    join_none

    // reset
    repeat (2) @(negedge clk);
    check("rst_state", 64'(state), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_strobes", 64'({mem_rd, mem_wr}), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    check("rst_instr", 64'(instr), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // fetch, ready on the first ACCESS cycle
    run(2'b00, 16'h0010, 16'h0000, 0);
    check("fetch_instr", 64'(instr), 64'(16'hA5C3));
    check("fetch_rdata", 64'(rdata), 64'(0));

    // store with three wait states
    run(2'b10, 16'h00FF, 16'h1234, 3);
    check("store_mem_wdata", 64'(mem_wdata), 64'(16'h1234));
    check("store_mem_addr", 64'(mem_addr), 64'(16'h00FF));

    // load to give rdata a value, then a timed-out load, then the boundary race
    run(2'b01, 16'h0020, 16'h0000, 1);
    run(2'b01, 16'h0030, 16'h0000, TIMEOUT);
    check("timeout_rdata_kept", 64'(rdata), 64'(ref_mem[8'h20]));
    run(2'b01, 16'h0031, 16'h0000, TIMEOUT - 1);
    check("race_rdata", 64'(rdata), 64'(ref_mem[8'h31]));

    // reserved op
    start(2'b11, 16'h0099, 16'hBEEF, 0, 1'b1);
    check("rsv_busy", 64'(busy), 64'(0));
    check("rsv_done", 64'(done), 64'(1));
    check("rsv_err", 64'(err), 64'(1));
    check("rsv_strobes", 64'({mem_rd, mem_wr}), 64'(0));
    check("rsv_mem_addr", 64'(mem_addr), 64'(16'h0031));
    wait_idle();

    // req pulsed while a load is busy must be ignored
    start(2'b01, 16'h0040, 16'h0000, 5, 1'b1);
    repeat (2) @(negedge clk);
    req = 1'b1; op = 2'b10; addr = 16'h0077; wdata = 16'h5555;
    @(negedge clk);
    req = 1'b0;
    wait_idle();
    check("ignored_req_addr", 64'(mem_addr), 64'(16'h0040));
    repeat (3) @(negedge clk);
    check("ignored_req_idle", 64'(state), 64'(0));

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      w = ($urandom_range(0, 5) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 2) : $urandom_range(0, 3);
      run((r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
          {8'($urandom), 8'($urandom_range(0, 15))}, DW'($urandom), w);
    end

    // asynchronous reset in the middle of ACCESS
    start(2'b00, 16'h0050, 16'h0000, 20, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_rd", 64'(mem_rd), 64'(0));
    check("abort_state", 64'(state), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_instr", 64'(instr), 64'(0));
    ref_instr = '0;
    ref_rdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_abort_mem_addr", 64'(mem_addr), 64'(0));
    run(2'b00, 16'h0010, 16'h0000, 2);
    run(2'b01, 16'h00FF, 16'h0000, 0);

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
